// File: rtl/ram_alu_pkg.sv
// Shared definitions for the RAM-driven ALU sequencer: default widths,
// ALU op encodings and the FSM state encoding.
package ram_alu_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 6;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_LOAD = 3'd3,
    S_EXEC = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: result plus signed overflow flag,
// where the flag is only meaningful for ADD and SUB and is 0 otherwise.
module seq_alu
  import ram_alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_result,
  output logic          o_ovf
);

  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_diff;
  logic          w_addOvf;
  logic          w_subOvf;

  assign w_sum    = i_a + i_b;
  assign w_diff   = i_a - i_b;
  assign w_addOvf = (i_a[DW-1] == i_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
  assign w_subOvf = (i_a[DW-1] != i_b[DW-1]) && (w_diff[DW-1] != i_a[DW-1]);

  // Ops 6 and 7 both pass operand b through unchanged.
  always_comb begin
    o_result = i_b;
    o_ovf    = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum;
        o_ovf    = w_addOvf;
      end
      OP_SUB: begin
        o_result = w_diff;
        o_ovf    = w_subOvf;
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLT:  o_result = {{(DW-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = i_b;
    endcase
  end

endmodule

// File: rtl/ram_alu_seq.sv
// Reads two seed words from an external synchronous RAM, then writes a
// recurrence of len results (a<=b, b<=f(a,b)) to the words after the seeds.
module ram_alu_seq
  import ram_alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] oa,
  output logic [DW-1:0] ob,
  output logic [DW-1:0] oc,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [AW-1:0] r_k;
  logic [2:0]    r_op;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_len;
  logic          r_ovf;

  logic [DW-1:0] w_result;
  logic          w_aluOvf;
  logic [AW-1:0] w_execAddr;
  logic          w_lastStep;

  seq_alu #(.DW(DW)) u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_result),
    .o_ovf    (w_aluOvf)
  );

  assign w_execAddr = r_base + AW'(2) + r_k;
  assign w_lastStep = (r_k == r_len - AW'(1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory outputs are decoded from the state so an async reset drops mem_we at once.
  always_comb begin
    w_next    = r_state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RD0;
      S_RD0: begin
        mem_addr = r_base;
        w_next   = S_RD1;
      end
      S_RD1: begin
        mem_addr = r_base + AW'(1);
        w_next   = S_LOAD;
      end
      S_LOAD: w_next = (r_len != '0) ? S_EXEC : S_DONE;
      S_EXEC: begin
        mem_we    = 1'b1;
        mem_addr  = w_execAddr;
        mem_wdata = w_result;
        if (w_lastStep) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_k    <= '0;
      r_op   <= '0;
      r_base <= '0;
      r_len  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_base <= base;
            r_len  <= len;
            r_k    <= '0;
            r_ovf  <= 1'b0;
          end
        end
        S_RD1:  r_a <= mem_rdata;
        S_LOAD: r_b <= mem_rdata;
        S_EXEC: begin
          r_a <= r_b;
          r_b <= w_result;
          r_k <= r_k + AW'(1);
          if (w_aluOvf) r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oa   = r_a;
  assign ob   = r_b;
  assign oc   = w_result;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign ovf  = r_ovf;

endmodule

// File: doc/ram_alu_seq.md
RAM_ALU_SEQ -- requirements
Module: ram_alu_seq

Interface
REQ-001 Parameter DW, default 32, datapath/memory word width.
REQ-002 Parameter AW, default 6, memory address width; memory depth 2^AW.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-high reset (asserted = 1 despite the name).
REQ-005 start  in  1  run request; sampled in IDLE only.
REQ-006 op  in  3  ALU op: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SLT signed, 6-7 pass b; latched at start.
REQ-007 base  in  AW  address of first seed word; latched at start.
REQ-008 len  in  AW  number of results to generate; latched at start.
REQ-009 mem_addr  out  AW  synchronous RAM address.
REQ-010 mem_rdata  in  DW  RAM read data, valid one cycle after mem_addr.
REQ-011 mem_we  out  1  RAM write enable.
REQ-012 mem_wdata  out  DW  RAM write data.
REQ-013 oa, ob, oc  out  DW each  operand a, operand b, current ALU result (debug).
REQ-014 busy  out  1  high from the cycle after an accepted start until DONE is left.
REQ-015 done  out  1  one-cycle pulse when a run completes.
REQ-016 ovf  out  1  sticky signed overflow of any ADD/SUB result written in the current run.

Function
REQ-017 FSM states IDLE, RD0, RD1, LOAD, EXEC, DONE; one state per cycle except EXEC.
REQ-018 IDLE: start=1 latches op/base/len, clears ovf and step counter k, goes to RD0; start=0 stays.
REQ-019 RD0: mem_addr=base; next RD1.
REQ-020 RD1: mem_addr=base+1; a<=mem_rdata; next LOAD.
REQ-021 LOAD: b<=mem_rdata; next EXEC if len!=0, else DONE.
REQ-022 EXEC: mem_we=1, mem_addr=base+2+k, mem_wdata=f(op,a,b); then a<=b, b<=result, k<=k+1; go to DONE when k==len-1, else stay.
REQ-023 DONE: done=1 for exactly one cycle; next IDLE.
REQ-024 Latency start-accept to done pulse = 4+len cycles; len=0 still reads both seeds, no writes.
REQ-025 All address arithmetic is modulo 2^AW (wraps, no error).
REQ-026 Results are DW-bit, truncated; SLT yields 1 or 0 zero-extended.
REQ-027 ovf set when ADD/SUB signed overflow occurs in an EXEC cycle; holds until next accepted start or reset.
REQ-028 start while busy is ignored; no queuing.
REQ-029 mem_we=0 in every state except EXEC; mem_addr=0 and mem_wdata=0 when not driven by REQ-019/020/022.
REQ-030 oc is the combinational ALU result of current a, b, latched op at all times.

Reset
REQ-031 rst_n=1 immediately forces state IDLE; a, b, k, latched op/base/len, ovf, done, mem_we all 0.
REQ-032 Reset mid-run aborts with no further writes, no done pulse; the partially written memory is left as is.
REQ-033 After reset release, the first start is accepted in the next IDLE cycle.

Structure
REQ-034 Shared package ram_alu_pkg holds op encodings, FSM state encoding, and default DW/AW constants.
REQ-035 One sub-module, seq_alu: combinational (op, a, b) -> (result, ovf), parametrised by DW.
REQ-036 The RAM is external; the block contains only the FSM, the a/b/k/config registers, and seq_alu.

Verification
REQ-037 Fibonacci: mem[0]=1, mem[1]=1, base=0, len=4, op=ADD -> writes 2,3,5,8 to addr 2..5; done exactly 8 cycles after start accepted; ovf=0.
REQ-038 Wrap: AW=6, base=62, seeds 5 and 3, len=2, op=SUB -> writes 2 to addr 0, then 1 to addr 1.
REQ-039 Overflow: seeds 0x7FFFFFFF and 1, len=1, op=ADD -> writes 0x80000000; ovf=1 held after done; next start clears it.
REQ-040 len=0: start -> two reads, no mem_we pulse, done 4 cycles after start accepted.
REQ-041 Reset mid-run: assert rst_n during 2nd EXEC of len=5 -> mem_we=0 same cycle, busy=0, no done, only one word written.
REQ-042 start pulsed while busy -> ignored; exactly one done per accepted start.
